// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface if_fetch_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-side initiator: owns the PC, issues one word request at a time,
// applies branch/jump redirects, squashes wrong-path responses and stops on
// the halt word.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] HALT_INSTN = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump_in,
    input  logic [25:0]       jump_address,
    if_fetch_ctrl_if.master   imem,
    output logic [31:0]       instn,
    output logic [31:0]       instn_pc,
    output logic              instn_valid,
    output logic              halted,
    output logic [31:0]       counter,
    output logic [31:0]       jump_counter,
    output logic [31:0]       branch_counter
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pending_pc;
    logic            squash;

    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            handshake;

    // Redirect decode: branch wins over jump; redirects are dead once halted.
    always_comb begin
        redirect        = 1'b0;
        redirect_target = pc;
        if (state != S_HALT) begin
            redirect = branch_taken || jump_in;
            if (branch_taken) begin
                redirect_target = branch_target;
            end else begin
                redirect_target = {6'b0, jump_address};
            end
        end
    end

    // Request is held off while a valid instruction is stalled in IF/ID.
    assign imem.imem_req  = reset && (state == S_REQ) && (!instn_valid || !stall);
    assign imem.imem_addr = pc;
    assign handshake      = imem.imem_req && imem.imem_ready;

    // Fetch FSM, PC, IF/ID output register and event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            pending_pc     <= '0;
            squash         <= 1'b0;
            instn          <= '0;
            instn_pc       <= '0;
            instn_valid    <= 1'b0;
            halted         <= 1'b0;
            counter        <= '0;
            jump_counter   <= '0;
            branch_counter <= '0;
        end else begin
            if (instn_valid && !stall) begin
                instn_valid <= 1'b0;
            end

            // A redirect flushes whatever sits in IF/ID, even under stall.
            if (redirect) begin
                instn_valid <= 1'b0;
                if (branch_taken) begin
                    branch_counter <= branch_counter + 32'd1;
                end else begin
                    jump_counter <= jump_counter + 32'd1;
                end
            end

            case (state)
                S_REQ: begin
                    if (handshake) begin
                        state <= S_WAIT;
                        if (redirect) begin
                            squash     <= 1'b1;
                            pending_pc <= redirect_target;
                        end
                    end else if (redirect) begin
                        pc <= redirect_target;
                    end
                end

                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        state  <= S_REQ;
                        squash <= 1'b0;
                        if (redirect) begin
                            pc <= redirect_target;
                        end else if (squash) begin
                            pc <= pending_pc;
                        end else if (imem.imem_rdata == HALT_INSTN) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            instn       <= imem.imem_rdata;
                            instn_pc    <= pc;
                            instn_valid <= 1'b1;
                            counter     <= counter + 32'd1;
                            pc          <= pc + 32'd4;
                        end
                    end else if (redirect) begin
                        squash     <= 1'b1;
                        pending_pc <= redirect_target;
                    end
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: behavioural instruction memory, delivery
// scoreboard and one task per scenario.
module tb_if_fetch_ctrl;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NO_STOP   = 32'hFFFF_FFF0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_in;
    logic [25:0] jump_address;
    logic [31:0] instn;
    logic [31:0] instn_pc;
    logic        instn_valid;
    logic        halted;
    logic [31:0] counter;
    logic [31:0] jump_counter;
    logic [31:0] branch_counter;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Memory model controls
    logic [31:0] stop_addr;
    logic [31:0] halt_addr;
    logic        halt_en;
    int          mem_lat;
    logic        mem_clear;
    logic        rv_m;
    logic [31:0] rd_m;
    int          resp_cnt;
    logic [31:0] resp_addr;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump_in        (jump_in),
        .jump_address   (jump_address),
        .imem           (bus),
        .instn          (instn),
        .instn_pc       (instn_pc),
        .instn_valid    (instn_valid),
        .halted         (halted),
        .counter        (counter),
        .jump_counter   (jump_counter),
        .branch_counter (branch_counter)
    );

    always #5 clk = ~clk;

    assign bus.imem_ready  = (bus.imem_addr != stop_addr);
    assign bus.imem_rvalid = rv_m;
    assign bus.imem_rdata  = rd_m;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (halt_en && a == halt_addr) return HALT_WORD;
        return (a >> 2) + 32'd1;
    endfunction

    // Memory: accepts on req&ready, answers mem_lat cycles later.
    always @(negedge clk) begin
        if (mem_clear) begin
            resp_cnt = 0;
            rv_m     = 1'b0;
            rd_m     = 32'd0;
        end else begin
            rv_m = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) begin
                    rv_m = 1'b1;
                    rd_m = word_at(resp_addr);
                end
            end
            if (bus.imem_req && bus.imem_ready) begin
                resp_addr = bus.imem_addr;
                resp_cnt  = mem_lat;
            end
        end
    end

    // Scoreboard: every new IF/ID load is popped against the expected queue.
    logic prev_valid = 1'b0;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        if (instn_valid && !(prev_valid && prev_stall)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL delivery: unexpected pc=%h instn=%h, nothing expected", instn_pc, instn);
            end else begin
                mon_e = exp_q.pop_front();
                if (instn_pc !== mon_e.pc || instn !== mon_e.word) begin
                    errors++;
                    $display("FAIL delivery: got pc=%h instn=%h, expected pc=%h instn=%h",
                             instn_pc, instn, mon_e.pc, mon_e.word);
                end
            end
        end
        prev_valid = instn_valid;
        prev_stall = stall;
    end

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] word);
        exp_t e;
        e.pc   = pc;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        jump_in       = 1'b0;
        jump_address  = 26'd0;
        mem_clear     = 1'b1;
        stop_addr     = NO_STOP;
        halt_en       = 1'b0;
        halt_addr     = 32'd0;
        mem_lat       = 1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic wait_counter(input logic [31:0] tgt, input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (counter == tgt) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    task automatic wait_req(input logic [31:0] a, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_redirect(input logic b, input logic [31:0] bt, input logic j, input logic [25:0] ja);
        branch_taken  = b;
        branch_target = bt;
        jump_in       = j;
        jump_address  = ja;
        @(posedge clk); #1;
        branch_taken  = 1'b0;
        jump_in       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        jump_in = 1'b0; jump_address = 26'd0; mem_clear = 1'b1; stop_addr = NO_STOP;
        halt_en = 1'b0; halt_addr = 32'd0; mem_lat = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (instn_valid !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL reset_flags: valid=%b halted=%b, expected 0 0", instn_valid, halted);
        end
        checks++;
        if (counter !== 32'd0 || jump_counter !== 32'd0 || branch_counter !== 32'd0) begin
            errors++; $display("FAIL reset_counters: %h %h %h, expected all 0", counter, jump_counter, branch_counter);
        end
        checks++;
        if (instn !== 32'd0 || instn_pc !== 32'd0) begin
            errors++; $display("FAIL reset_instn: instn=%h pc=%h, expected 0 0", instn, instn_pc);
        end
        checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'd0) begin
            errors++; $display("FAIL reset_bus: req=%b addr=%h, expected 0 0", bus.imem_req, bus.imem_addr);
        end
        @(posedge clk); #1;
        mem_clear = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin
            errors++; $display("FAIL first_req: req=%b addr=%h, expected 1 00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        int n;
        do_reset();
        stop_addr = 32'hC;
        push_exp(32'h0, 32'h1);
        push_exp(32'h4, 32'h2);
        push_exp(32'h8, 32'h3);
        wait_counter(32'd3, 30, ok, n);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL seq_timeout: counter=%0d, expected 3", counter);
        end
        checks++;
        if (n != 6) begin
            errors++; $display("FAIL seq_throughput: third delivery after %0d cycles, expected 6", n);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (counter !== 32'd3 || branch_counter !== 32'd0 || jump_counter !== 32'd0) begin
            errors++; $display("FAIL seq_counters: %0d %0d %0d, expected 3 0 0", counter, branch_counter, jump_counter);
        end
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
            errors++; $display("FAIL seq_held_req: req=%b addr=%h, expected 1 0000000c", bus.imem_req, bus.imem_addr);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL seq_pending: %0d deliveries missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_branch_squash();
        bit ok;
        int n;
        logic [31:0] addr;
        do_reset();
        mem_lat = 3;
        push_exp(32'h0, 32'h1);
        push_exp(32'h4, 32'h2);
        wait_req(32'h8, 40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL br_reach8: request to 8 not seen, expected it");
        end
        @(posedge clk); #1;
        push_exp(32'h40, 32'h11);
        pulse_redirect(1'b1, 32'h40, 1'b0, 26'd0);
        stop_addr = 32'h44;
        addr = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                addr = bus.imem_addr;
                break;
            end
        end
        checks++;
        if (addr !== 32'h40) begin
            errors++; $display("FAIL br_next_addr: got %h, expected 00000040", addr);
        end
        wait_counter(32'd3, 30, ok, n);
        checks++;
        if (!ok || branch_counter !== 32'd1 || jump_counter !== 32'd0) begin
            errors++; $display("FAIL br_counters: cnt=%0d br=%0d jmp=%0d, expected 3 1 0", counter, branch_counter, jump_counter);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || counter !== 32'd3) begin
            errors++; $display("FAIL br_pending: left=%0d cnt=%0d, expected 0 3", exp_q.size(), counter);
        end
    endtask

    task automatic test_priority();
        bit ok;
        int n;
        int bad;
        do_reset();
        stop_addr = 32'h0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL addr_stable: %0d unstable cycles, expected 0", bad);
        end
        @(posedge clk); #1;
        push_exp(32'h80, 32'h21);
        pulse_redirect(1'b1, 32'h80, 1'b1, 26'h10);
        stop_addr = 32'h84;
        @(negedge clk);
        checks++;
        if (bus.imem_addr !== 32'h80 || branch_counter !== 32'd1 || jump_counter !== 32'd0) begin
            errors++; $display("FAIL prio: addr=%h br=%0d jmp=%0d, expected 00000080 1 0",
                               bus.imem_addr, branch_counter, jump_counter);
        end
        wait_counter(32'd1, 20, ok, n);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL prio_fetch: counter=%0d, expected 1", counter);
        end
        // Jump in the same cycle the request to 0x84 is accepted: its response is squashed.
        @(posedge clk); #1;
        stop_addr = 32'h30;
        pulse_redirect(1'b0, 32'd0, 1'b1, 26'h30);
        wait_req(32'h30, 10, ok);
        checks++;
        if (!ok || jump_counter !== 32'd1 || branch_counter !== 32'd1) begin
            errors++; $display("FAIL jump_squash: seen=%b jmp=%0d br=%0d, expected 1 1 1", ok, jump_counter, branch_counter);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (counter !== 32'd1 || exp_q.size() != 0) begin
            errors++; $display("FAIL jump_drop: cnt=%0d left=%0d, expected 1 0", counter, exp_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        int n;
        int bad;
        do_reset();
        stall = 1'b1;
        push_exp(32'h0, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instn_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL stall_load: instn_valid never set, expected 1");
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (instn !== 32'h1 || instn_pc !== 32'h0 || instn_valid !== 1'b1 || bus.imem_req !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_hold: %0d bad cycles, expected 0", bad);
        end
        @(posedge clk); #1;
        stall     = 1'b0;
        stop_addr = 32'h8;
        push_exp(32'h4, 32'h2);
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || counter !== 32'd1) begin
            errors++; $display("FAIL stall_release: req=%b addr=%h cnt=%0d, expected 1 00000004 1",
                               bus.imem_req, bus.imem_addr, counter);
        end
        wait_counter(32'd2, 20, ok, n);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL stall_next: counter=%0d, expected 2", counter);
        end
    endtask

    task automatic test_halt();
        bit ok;
        int bad;
        do_reset();
        halt_en   = 1'b1;
        halt_addr = 32'hC;
        push_exp(32'h0, 32'h1);
        push_exp(32'h4, 32'h2);
        push_exp(32'h8, 32'h3);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL halt_seen: halted=%b, expected 1", halted);
        end
        checks++;
        if (instn_valid !== 1'b0 || counter !== 32'd3) begin
            errors++; $display("FAIL halt_state: valid=%b cnt=%0d, expected 0 3", instn_valid, counter);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                @(posedge clk); #1;
                pulse_redirect(1'b1, 32'h100, 1'b0, 26'd0);
            end
            @(negedge clk);
            if (bus.imem_req !== 1'b0 || instn_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL halt_quiet: %0d active cycles, expected 0", bad);
        end
        checks++;
        if (halted !== 1'b1 || counter !== 32'd3 || branch_counter !== 32'd0 || jump_counter !== 32'd0) begin
            errors++; $display("FAIL halt_frozen: halted=%b cnt=%0d br=%0d jmp=%0d, expected 1 3 0 0",
                               halted, counter, branch_counter, jump_counter);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int n;
        int bad;
        do_reset();
        mem_lat = 3;
        wait_req(32'h0, 5, ok);
        @(posedge clk); #1;
        reset     = 1'b0;
        stop_addr = 32'h0;
        @(posedge clk); #1;
        reset = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (instn_valid !== 1'b0 || counter !== 32'd0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) bad++;
        end
        checks++;
        if (!ok || bad != 0) begin
            errors++; $display("FAIL late_rvalid: req_seen=%b bad=%0d, expected 1 0", ok, bad);
        end
        @(posedge clk); #1;
        stop_addr = 32'h4;
        push_exp(32'h0, 32'h1);
        wait_counter(32'd1, 20, ok, n);
        checks++;
        if (!ok || branch_counter !== 32'd0 || jump_counter !== 32'd0) begin
            errors++; $display("FAIL post_reset_fetch: cnt=%0d br=%0d jmp=%0d, expected 1 0 0",
                               counter, branch_counter, jump_counter);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_squash();
        test_priority();
        test_stall();
        test_halt();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
